prbs_pattern_gen: RTL
=====================

Name: prbs_pattern_gen

Overview:
Stimulus source that sits directly upstream of the byte-wide pattern detector. On a start pulse it emits a programmable number of back-to-back copies of a 32-bit sync pattern, MSB byte first. It then emits a fixed-length run of PRBS-15 payload bytes and signals completion. A downstream enable stalls it, so the detector, or any byte sink, can consume one byte per enabled cycle.

Parameters:
PATTERN, 32'hAABBCCDD, sync word; bytes are sent [31:24], [23:16], [15:8], [7:0].
SEED, 15'h7FFF, LFSR value reloaded on every accepted start; must be non-zero.
PRBS_BYTES, 16, number of PRBS bytes after the pattern phase (1..255).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a frame; ignored unless idle.
n  input  8  number of pattern repetitions; sampled when start is accepted.
en  input  1  downstream enable; a byte is consumed on a cycle with out_valid=1 and en=1.
out  output  8  current byte.
out_valid  output  1  out holds a valid byte.
busy  output  1  frame in progress, from the cycle after start through the last consumed byte.
done  output  1  one-cycle pulse after the last PRBS byte is consumed.

Behaviour:
- Reset (async, RST=1): state IDLE; out=8'h00, out_valid=0, busy=0, done=0; rep_cnt=0, byte_idx=0, prbs_cnt=0, lfsr=SEED.
- FSM states: IDLE, PAT, PRBS, FIN.
- IDLE, start=1:
  - Latch n, load lfsr=SEED, set busy=1.
  - n!=0: go to PAT with byte_idx=0.
  - n==0: go to PRBS directly.
  - out_valid rises the cycle after start (1-cycle latency).
- PAT:
  - out = PATTERN byte selected by byte_idx (0 = [31:24]).
  - On each consumed byte, byte_idx increments mod 4.
  - When byte_idx wraps from 3 to 0, rep_cnt increments.
  - When rep_cnt reaches the latched n on that wrap, go to PRBS.
  - No idle cycle between pattern copies or between PAT and PRBS.
- PRBS:
  - LFSR is x^15+x^14+1. Per bit: new = lfsr[14]^lfsr[13]; lfsr <= {lfsr[13:0], new}.
  - Each byte is 8 successive new bits, first bit in out[7]. The next byte's bits (8 steps) are computed combinationally in one cycle.
  - out shows the current byte. The LFSR advances 8 steps only when that byte is consumed.
  - After PRBS_BYTES consumed bytes, go to FIN.
- FIN (one cycle): out_valid=0, busy=0, done=1; then IDLE.
- Stall (en=0 while out_valid=1): out, out_valid, all counters and lfsr hold unchanged.
- start while busy or in FIN: ignored, no restart, n not re-latched.
- start in the same cycle done=1: ignored. The next frame needs start in IDLE.
- out=8'h00 whenever out_valid=0.
- RST mid-frame: immediate return to reset values. The partial frame is abandoned and no done is issued.
- Widths:
  - rep_cnt is 8 bits and compares against the latched n.
  - prbs_cnt is 8 bits and compares against PRBS_BYTES-1 on the consuming cycle.
  - n=255 is legal (1020 pattern bytes).

Test Plan:
1. Reset, then start with n=2, en=1 -> out_valid from cycle +1.
   - Bytes: AA BB CC DD AA BB CC DD, then PRBS 00 02 ...
   - 24 valid cycles, then done pulse, busy low.
2. n=0, start, en=1 -> first byte 00, second 02; exactly 16 PRBS bytes, then done.
3. n=1, en toggled 1,0,0,1,... -> each byte holds through its en=0 cycles.
   - Sequence AA BB CC DD 00 02 unchanged; no bytes duplicated or skipped.
4. start pulsed again mid-frame with n=5 -> ignored; the frame completes with the original n=1 (4 pattern bytes).
5. RST asserted during the PRBS phase -> out_valid=0, out=00, busy=0 asynchronously, no done.
   - A new start with n=1 replays AA BB CC DD 00 02 (LFSR reseeded).
6. Back-to-back frames (start one cycle after done) -> the second frame's PRBS bytes are identical to the first's.

Source files
------------

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen: byte-wide stimulus source.
// On an accepted start it emits n copies of the 32-bit sync word, MSB byte first,
// then PRBS_BYTES bytes of PRBS-15 (x^15+x^14+1) payload, then pulses done.
// A downstream enable stalls the stream. A byte is consumed on out_valid & en.
module prbs_pattern_gen #(
    parameter logic [31:0] PATTERN    = 32'hAABBCCDD,
    parameter logic [14:0] SEED       = 15'h7FFF,
    parameter int unsigned PRBS_BYTES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] n,
    input  logic       en,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PAT  = 2'd1;
    localparam logic [1:0] PRBS = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [7:0] PRBS_LAST = 8'(PRBS_BYTES - 1);

    logic [1:0]  state;
    logic [7:0]  n_lat;
    logic [7:0]  rep_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  prbs_cnt;
    logic [14:0] lfsr;
    logic [14:0] lfsr_next8;
    logic [7:0]  pat_byte;

    // Advance the LFSR eight steps at once. The eight new bits land in the low byte, oldest in bit 7.
    always_comb begin
        lfsr_next8 = lfsr;
        for (int unsigned i = 0; i < 8; i++) begin
            lfsr_next8 = {lfsr_next8[13:0], lfsr_next8[14] ^ lfsr_next8[13]};
        end
    end

    // Select the sync-word byte for the current position, MSB byte first.
    always_comb begin
        pat_byte = '0;
        case (byte_idx)
            2'd0:    pat_byte = PATTERN[31:24];
            2'd1:    pat_byte = PATTERN[23:16];
            2'd2:    pat_byte = PATTERN[15:8];
            default: pat_byte = PATTERN[7:0];
        endcase
    end

    // Decode the outputs from the registered state so that reset clears them at once.
    always_comb begin
        out_valid = (state == PAT) || (state == PRBS);
        busy      = out_valid;
        done      = (state == FIN);
        out       = '0;
        if (state == PAT) begin
            out = pat_byte;
        end else if (state == PRBS) begin
            out = lfsr_next8[7:0];
        end
    end

    // Frame sequencing. Counters and the LFSR only move on a consumed byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            n_lat    <= '0;
            rep_cnt  <= '0;
            byte_idx <= '0;
            prbs_cnt <= '0;
            lfsr     <= SEED;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat    <= n;
                        lfsr     <= SEED;
                        rep_cnt  <= '0;
                        byte_idx <= '0;
                        prbs_cnt <= '0;
                        state    <= (n != 8'd0) ? PAT : PRBS;
                    end
                end
                PAT: begin
                    if (en) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            rep_cnt <= rep_cnt + 8'd1;
                            if (rep_cnt + 8'd1 == n_lat) begin
                                state <= PRBS;
                            end
                        end
                    end
                end
                PRBS: begin
                    if (en) begin
                        lfsr <= lfsr_next8;
                        if (prbs_cnt == PRBS_LAST) begin
                            state <= FIN;
                        end else begin
                            prbs_cnt <= prbs_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
